// File: rtl/apb_master_n.sv
// apb_master_n: core bus (transfer/ready) to APB3 bridge with arithmetic region decode.
// Optional PREADY watchdog is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_n #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                NUM_SLAVES     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(32'h1000_0000),
    parameter int                REGION_BITS    = 12,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic                         ready,
    output logic [DATA_W-1:0]            rdata,
    output logic                         err,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
            $error("apb_master_n: NUM_SLAVES must be in 1..16");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("apb_master_n: TIMEOUT_CYCLES must be in 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_q,   state_d;
    logic [3:0]              idx_q,     idx_d;
    logic                    hit_q,     hit_d;
    logic [ADDR_W-1:0]       paddr_q,   paddr_d;
    logic [DATA_W-1:0]       pwdata_q,  pwdata_d;
    logic                    pwrite_q,  pwrite_d;
    logic                    penable_q, penable_d;
    logic [NUM_SLAVES-1:0]   psel_q,    psel_d;

    logic [ADDR_W-1:0]       off_s;
    logic [ADDR_W-1:0]       idx_full_s;
    logic                    dec_hit_s;
    logic [3:0]              dec_idx_s;
    logic [NUM_SLAVES-1:0]   dec_onehot_s;
    logic                    sel_ready_s;
    logic                    sel_err_s;
    logic [DATA_W-1:0]       sel_rdata_s;
    logic                    tmo_hit_s;
    logic                    done_s;
    logic                    load_s;

    // Addresses below BASE_ADDR wrap to a huge offset, so the lower-bound test is explicit.
    assign off_s      = addr - BASE_ADDR;
    assign idx_full_s = off_s >> REGION_BITS;
    assign dec_hit_s  = (addr >= BASE_ADDR) && (idx_full_s < ADDR_W'(NUM_SLAVES));
    assign dec_idx_s  = idx_full_s[3:0];

    // Select-line pattern for the incoming request and response mux for the latched slave.
    always_comb begin
        dec_onehot_s = '0;
        sel_ready_s  = 1'b0;
        sel_err_s    = 1'b0;
        sel_rdata_s  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dec_onehot_s[i] = dec_hit_s && (dec_idx_s == 4'(i));
            sel_ready_s     = (idx_q == 4'(i)) ? PREADY[i]  : sel_ready_s;
            sel_err_s       = (idx_q == 4'(i)) ? PSLVERR[i] : sel_err_s;
            sel_rdata_s     = (idx_q == 4'(i)) ? PRDATA[i*DATA_W +: DATA_W] : sel_rdata_s;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit_s = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) && !sel_ready_s;
    assign tmo_cnt_d = ((state_q == ST_ACCESS) && !done_s) ? (tmo_cnt_q + 16'd1) : 16'd0;

    // Watchdog counter of non-completing ACCESS cycles.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // A miss completes immediately; a timeout completes with the slave still not ready.
    assign done_s = (state_q == ST_ACCESS) && (!hit_q || sel_ready_s || tmo_hit_s);
    assign load_s = transfer && ((state_q == ST_IDLE) || done_s);

    assign ready = done_s;
    assign rdata = (done_s && hit_q && sel_ready_s && !pwrite_q) ? sel_rdata_s : '0;
    assign err   = done_s && (!hit_q || !sel_ready_s || sel_err_s);

    // Next-state and APB output sequencing.
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            ST_IDLE: begin
                state_d = transfer ? ST_SETUP : ST_IDLE;
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                state_d   = done_s ? (transfer ? ST_SETUP : ST_IDLE) : ST_ACCESS;
                penable_d = !done_s;
                psel_d    = done_s ? '0 : psel_q;
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
        idx_d    = load_s ? dec_idx_s    : idx_q;
        hit_d    = load_s ? dec_hit_s    : hit_q;
        paddr_d  = load_s ? addr         : paddr_q;
        pwdata_d = load_s ? wdata        : pwdata_q;
        pwrite_d = load_s ? write        : pwrite_q;
        psel_d   = load_s ? dec_onehot_s : psel_d;
    end

    // State and request registers.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            hit_q     <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;

endmodule

// File: tb/tb_apb_master_n.sv
// Bench for apb_master_n: transaction-level model with per-cycle compare plus literal latency checks.
module tb_apb_master_n;
    localparam int          NS   = 8;
    localparam int          DW   = 32;
    localparam int          TO_N = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic PCLK = 1'b0, PRESET = 1'b0, transfer = 1'b0, write = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic ready, err, PWRITE, PENABLE;
    logic [31:0] rdata, PADDR, PWDATA;
    logic [NS-1:0] PSEL, PREADY = '1, PSLVERR = '0;
    logic [NS*DW-1:0] PRDATA = '0;

    apb_master_n #(.TIMEOUT_CYCLES(TO_N)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int total = 0, bad = 0, cyc = 0, t0 = 0;
    bit chk_en = 1'b0, rst_n_v = 1'b0;

    // pending core requests (slave behaviour travels with each request)
    logic [31:0] q_addr[$], q_wdata[$], q_rd[$];
    bit          q_w[$], q_se[$];
    int          q_wait[$];

    // model of the transaction in flight; m_k = cycles since acceptance (1 = setup)
    bit m_act = 1'b0, m_w, m_se, m_hit, m_tmo;
    int m_k, m_done, m_idx, m_wait;
    logic [31:0] m_a, m_d, m_rd;

    logic [31:0] exp_rdata = 32'd0, exp_paddr, exp_pwdata;
    logic [NS-1:0] exp_psel = '0;
    bit exp_ready = 1'b0, exp_err = 1'b0, exp_pen = 1'b0, exp_pwrite;

    int obs_cyc[$];
    logic [31:0] obs_rd[$];
    bit obs_err[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void decode(input logic [31:0] a, output bit h, output int ix);
        logic [31:0] off;
        off = a - BASE;
        ix  = int'(off >> 12);
        h   = (a >= BASE) && (ix < NS);
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] d, input bit w,
                        input int wt, input logic [31:0] rd, input bit se);
        q_addr.push_back(a); q_wdata.push_back(d); q_w.push_back(w);
        q_wait.push_back(wt); q_rd.push_back(rd); q_se.push_back(se);
    endtask

    task automatic accept();
        int j;
        m_a = q_addr.pop_front(); m_d = q_wdata.pop_front(); m_w = q_w.pop_front();
        m_wait = q_wait.pop_front(); m_rd = q_rd.pop_front(); m_se = q_se.pop_front();
        decode(m_a, m_hit, m_idx);
        m_tmo = 1'b0;
        if (!m_hit) j = 1;
        else if (TO_EN && (m_wait < 0 || m_wait >= TO_N)) begin j = TO_N; m_tmo = 1'b1; end
        else if (m_wait < 0) j = 1 << 30;
        else j = m_wait + 1;
        m_done = 1 + j;
        m_k = 1;
        m_act = 1'b1;
    endtask

    // one clock: advance the model over the edge, then drive the next cycle's inputs
    task automatic tick();
        @(posedge PCLK);
        cyc++;
        if (!PRESET) m_act = 1'b0;
        else if (m_act && m_k == m_done) begin
            m_act = 1'b0;
            if (transfer) accept();
        end
        else if (m_act) m_k++;
        else if (transfer) accept();
        #1;
        PRESET   = rst_n_v;
        transfer = rst_n_v && (q_addr.size() > 0);
        if (q_addr.size() > 0) begin
            addr = q_addr[0]; wdata = q_wdata[0]; write = q_w[0];
        end
        for (int i = 0; i < NS; i++) begin
            PREADY[i] = 1'b1; PSLVERR[i] = 1'b1;
            PRDATA[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
        end
        exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0; exp_psel = '0; exp_pen = 1'b0;
        if (m_act) begin
            exp_paddr = m_a; exp_pwdata = m_d; exp_pwrite = m_w;
            exp_pen = (m_k >= 2);
            if (m_hit) begin
                exp_psel = NS'(1 << m_idx);
                PSLVERR[m_idx] = m_se;
                PRDATA[m_idx*DW +: DW] = m_rd;
                PREADY[m_idx] = (m_k < 2) ? 1'b1 : (m_wait >= 0 && (m_k - 1) > m_wait);
            end
            if (m_k == m_done) begin
                exp_ready = 1'b1;
                exp_err   = !m_hit || m_tmo || m_se;
                exp_rdata = (m_hit && !m_tmo && !m_w) ? m_rd : 32'd0;
            end
        end
    endtask

    task automatic run(input int maxc);
        int n = 0;
        while ((m_act || q_addr.size() > 0) && n < maxc) begin
            tick();
            n++;
        end
        chk("run_within_budget", 32'(n < maxc), 32'd1);
        tick();
    endtask

    task automatic expect_ready(input string nm, input int c, input logic [31:0] rd, input bit e);
        if (obs_cyc.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: got no ready expected ready at cycle %0d", nm, c);
        end else begin
            chk({nm, "_cycle"}, 32'(obs_cyc.pop_front()), 32'(c));
            chk({nm, "_rdata"}, obs_rd.pop_front(), rd);
            chk({nm, "_err"}, 32'(obs_err.pop_front()), 32'(e));
        end
    endtask

    task automatic start();
        tick();
        t0 = cyc;
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("rdata", rdata, exp_rdata);
            chk("err", 32'(err), 32'(exp_err));
            chk("psel", 32'(PSEL), 32'(exp_psel));
            chk("penable", 32'(PENABLE), 32'(exp_pen));
            if (m_act) begin
                chk("paddr", PADDR, exp_paddr);
                chk("pwdata", PWDATA, exp_pwdata);
                chk("pwrite", 32'(PWRITE), 32'(exp_pwrite));
            end
            if (ready === 1'b1) begin
                obs_cyc.push_back(cyc); obs_rd.push_back(rdata); obs_err.push_back(err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "bench time limit");
    end

    initial begin
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        rst_n_v = 1'b1;
        tick(); tick();

        // zero-wait write to slave 4
        push(32'h1000_4000, 32'hDEAD_BEEF, 1'b1, 0, 32'd0, 1'b0);
        start();
        tick();
        chk("wr_setup_psel", 32'(PSEL), 32'h10);
        chk("wr_setup_penable", 32'(PENABLE), 32'd0);
        tick();
        chk("wr_access_penable", 32'(PENABLE), 32'd1);
        chk("wr_access_ready", 32'(ready), 32'd1);
        run(20);
        expect_ready("wr0", t0 + 2, 32'd0, 1'b0);

        // three wait states on slave 1
        push(32'h1000_1008, 32'd0, 1'b0, 3, 32'h1234_5678, 1'b0);
        start(); run(20);
        expect_ready("rd_wait3", t0 + 5, 32'h1234_5678, 1'b0);

        // decode misses above and below the mapped window
        push(32'h1000_8000, 32'd0, 1'b0, 0, 32'h9999_9999, 1'b0);
        start(); run(20);
        expect_ready("miss_hi", t0 + 2, 32'd0, 1'b1);
        push(32'h0FFF_FFFC, 32'd0, 1'b0, 0, 32'h9999_9999, 1'b0);
        start(); run(20);
        expect_ready("miss_lo", t0 + 2, 32'd0, 1'b1);

        // slave error on slave 2, one wait state
        push(32'h1000_2000, 32'h0000_00FF, 1'b1, 1, 32'd0, 1'b1);
        start(); run(20);
        expect_ready("slverr", t0 + 3, 32'd0, 1'b1);

        // last address of the last region
        push(32'h1000_7FFC, 32'd0, 1'b0, 0, 32'hCAFE_F00D, 1'b0);
        start(); run(20);
        expect_ready("top_edge", t0 + 2, 32'hCAFE_F00D, 1'b0);

        // back-to-back: slave 0 read then slave 6 write
        push(32'h1000_0010, 32'd0, 1'b0, 0, 32'hA5A5_5A5A, 1'b0);
        push(32'h1000_6004, 32'h0BAD_CAFE, 1'b1, 0, 32'd0, 1'b0);
        start(); run(20);
        expect_ready("b2b_first", t0 + 2, 32'hA5A5_5A5A, 1'b0);
        expect_ready("b2b_second", t0 + 4, 32'd0, 1'b0);

        // slave 3 never ready
        push(32'h1000_3000, 32'd0, 1'b0, -1, 32'h1111_1111, 1'b0);
        start();
`ifdef APB_MASTER_TIMEOUT_EN
        run(50);
        expect_ready("watchdog", t0 + 5, 32'd0, 1'b1);
`else
        while (cyc < t0 + 100) tick();
        chk("hang_penable", 32'(PENABLE), 32'd1);
        chk("hang_psel", 32'(PSEL), 32'h08);
        chk("hang_no_ready", 32'(obs_cyc.size()), 32'd0);
        rst_n_v = 1'b0; tick();
        rst_n_v = 1'b1; tick();
        chk("hang_reset_psel", 32'(PSEL), 32'd0);
        tick();
`endif

        // reset during wait states, then a normal transfer
        push(32'h1000_5000, 32'd0, 1'b0, 10, 32'h5555_AAAA, 1'b0);
        start(); tick(); tick(); tick();
        rst_n_v = 1'b0; tick();
        rst_n_v = 1'b1; tick();
        chk("midrst_psel", 32'(PSEL), 32'd0);
        chk("midrst_penable", 32'(PENABLE), 32'd0);
        chk("midrst_no_ready", 32'(obs_cyc.size()), 32'd0);
        push(32'h1000_5004, 32'd0, 1'b0, 0, 32'h7777_8888, 1'b0);
        start(); run(20);
        expect_ready("after_rst", t0 + 2, 32'h7777_8888, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_master_n.md
Name: apb_master_n

Overview:
- Parametrised successor to the fixed 8-slave APB_Master in the MCU top.
- Bridges the RV32I_Core internal bus (transfer/ready/addr/wdata/rdata/write) to an APB3 fabric with NUM_SLAVES select lines.
- Decodes slave regions arithmetically from a base address instead of using a hard-coded map.
- Adds features the current master lacks: PSLVERR/decode-error reporting, back-to-back transfers, and an optional PREADY watchdog.

Parameters:
- ADDR_W, 32, width of addr/PADDR.
- DATA_W, 32, width of wdata/rdata/PWDATA/PRDATA.
- NUM_SLAVES, 8, number of APB slaves; legal range 1..16.
- BASE_ADDR, 32'h1000_0000, address of slave 0 region.
- REGION_BITS, 12, log2 of region size; slave i spans BASE_ADDR + i*2^REGION_BITS for 2^REGION_BITS bytes.
- TIMEOUT_CYCLES, 255, ACCESS cycles before watchdog abort; legal range 1..65535.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-low reset.
- transfer  in  1  request strobe from core.
- write  in  1  1=write, 0=read.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- ready  out  1  transfer-complete pulse.
- rdata  out  DATA_W  read data, valid when ready=1.
- err  out  1  error flag, valid when ready=1.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES*DATA_W  flattened read data; slave i occupies bits [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (PRESET=0 at a PCLK edge): state=IDLE; PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, internal timeout counter=0. ready, rdata, err are combinational and read 0 in IDLE. Reset mid-transfer aborts immediately; no ready is issued.
- Decode:
  - offset = addr - BASE_ADDR (unsigned ADDR_W).
  - idx = offset >> REGION_BITS.
  - hit = addr >= BASE_ADDR and idx < NUM_SLAVES.
  - idx, hit, addr, wdata and write are latched on acceptance.
- FSM IDLE -> SETUP -> ACCESS:
  - IDLE: if transfer=1, latch request, go to SETUP. Otherwise stay.
  - SETUP: PSEL[idx]=hit, PENABLE=0, PADDR/PWDATA/PWRITE driven from the latched request. Unconditionally go to ACCESS; clear the timeout counter.
  - ACCESS: PSEL held, PENABLE=1. The transfer completes when any of these holds:
    - hit=1 and PREADY[idx]=1;
    - hit=0 (decode miss completes in its first ACCESS cycle; no PSEL is ever asserted);
    - watchdog expiry (see Optional Feature).
  - Completion cycle outputs:
    - ready=1 for exactly that one cycle.
    - rdata = PRDATA slice[idx] on a hit read; 0 on writes, misses and timeouts.
    - err = PSLVERR[idx] on a hit, 1 on a miss, 1 on a timeout.
  - Next state after completion: SETUP if transfer=1 in that same cycle (back-to-back; new request latched), else IDLE.
  - Not complete: stay in ACCESS; PADDR/PWDATA/PWRITE/PSEL held stable.
- transfer asserted in SETUP, or in a non-completing ACCESS cycle, is ignored. The core holds its request until ready.
- Latency: transfer at cycle T, zero-wait slave gives ready at T+2. Each PREADY-low cycle adds one.
- PREADY/PSLVERR of unselected slaves are ignored.
- Elaboration error when NUM_SLAVES is out of range.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - 16-bit counter increments in each non-completing ACCESS cycle.
  - When the counter equals TIMEOUT_CYCLES-1 and PREADY[idx]=0, the transfer completes with ready=1, err=1, rdata=0, and PSEL/PENABLE drop next cycle.
  - With TIMEOUT_CYCLES=N, ready occurs on the Nth ACCESS cycle at the latest.
- Undefined: no counter logic; ACCESS waits on PREADY indefinitely.

Test Plan:
- Zero-wait write: reset; write addr=0x1000_4000, wdata=0xDEAD_BEEF; slave 4 PREADY=1. Expect PSEL=0x10, PENABLE low at T+1 and high at T+2, ready=1 at T+2, err=0.
- Wait-state read: read addr=0x1000_1008; slave 1 holds PREADY=0 for 3 cycles, then 1 with PRDATA=0x1234_5678. Expect ready at T+5, rdata=0x1234_5678, PADDR stable throughout.
- Decode miss and slave error:
  - addr=0x1000_8000 (idx=8): expect PSEL=0 throughout, ready=1 at T+2, err=1, rdata=0.
  - addr=0x0FFF_FFFC: same result.
  - slave 2 returns PSLVERR=1: expect err=1.
- Back-to-back: hold transfer high across two requests (slave 0, then slave 6, both zero-wait). Expect ready at T+2 and T+4, SETUP at T+3 with no IDLE cycle, PSEL 0x01 then 0x40.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave 3 never ready. Expect ready=1, err=1 at T+5, PSEL=0 at T+6. Without the macro: still in ACCESS at T+100.
- Reset mid-ACCESS: drive PRESET=0 during wait states. Expect next cycle PSEL=0, PENABLE=0, no ready; a new transfer after release completes normally.
